dma_fifo_wr_arbiter: RTL and testbench
======================================

# dma_fifo_wr_arbiter

Write-side scheduler for the DMA shared transfer FIFO. It arbitrates round-robin among NCH channel requesters and grants one channel a fixed-length burst into the FIFO. A burst is granted only when the FIFO holds enough free entries for the whole burst. The block owns the FIFO write pointer, which it keeps in binary and publishes in Gray code. It converts the read pointer, already synchronized into its domain, from Gray to binary to compute occupancy.

## Interface
- PTR, 4, FIFO address width; depth = 2^PTR; pointers are PTR+1 bits (extra wrap bit)
- NCH, 4, number of requesting channels (2..8)
- BURST, 4, beats per burst (1..2^PTR)

- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NCH  per-channel burst request, level
- src_valid  input  1  granted channel has a beat available this cycle
- rd_ptr_gray  input  PTR+1  FIFO read pointer, Gray, already synchronized to clk
- gnt  output  NCH  one-hot grant, registered, held for the whole burst
- wr_en  output  1  FIFO write strobe
- wr_addr  output  PTR  FIFO write address = wr_bin[PTR-1:0]
- wr_ptr_gray  output  PTR+1  write pointer, Gray, registered
- free_cnt  output  PTR+1  free entries = 2^PTR − ((wr_bin − rd_bin) mod 2^(PTR+1))
- full  output  1  free_cnt == 0
- burst_done  output  1  one-cycle pulse on the last beat of a burst

## Operation
- Read-pointer conversion: rd_bin[PTR] = g[PTR]; rd_bin[i] = rd_bin[i+1] ^ g[i]. Combinational, used the same cycle.
- Write pointer: wr_bin is PTR+1 bits and increments by 1 per write, wrapping from 2^(PTR+1)−1 to 0. wr_ptr_gray = wr_bin ^ (wr_bin >> 1), registered together with wr_bin.
- free_cnt and full are combinational from wr_bin and rd_bin. Subtraction is modulo 2^(PTR+1).
- Two-state FSM:
  - IDLE: gnt = 0, wr_en = 0. If any req and free_cnt ≥ BURST, select the first requesting channel searching from (last+1) mod NCH upward with wrap. Register its one-hot gnt, clear beat_cnt, and go to BURST. Otherwise stay in IDLE.
  - BURST: wr_en = src_valid (combinational). On each write, wr_bin and beat_cnt increment. When a write occurs with beat_cnt == BURST−1: pulse burst_done, set last = granted index, clear gnt, return to IDLE.
- req is sampled only in IDLE. Deasserting req mid-burst has no effect; the burst runs until BURST beats have been written.
- src_valid low in BURST: no write and no pointer change. gnt is held indefinitely; there is no timeout.
- Overflow is impossible by construction: free space is checked for the full burst at grant time, and reads only add space.
- rd_ptr_gray movement during a burst changes free_cnt only. It never alters an in-progress burst.
- Reset: state IDLE, wr_bin = 0, wr_ptr_gray = 0, gnt = 0, wr_en = 0, burst_done = 0, beat_cnt = 0, last = NCH−1 (channel 0 wins first). With rd_ptr_gray = 0, free_cnt = 2^PTR and full = 0.
- Reset asserted mid-burst: the burst is abandoned immediately and the pointer returns to 0. The FIFO is reset in the same reset domain.

## Timing
- Grant latency: req seen in IDLE at edge N → gnt valid after edge N, so the first wr_en is possible in the cycle following edge N.
- Burst length: exactly BURST wr_en cycles, BURST cycles minimum when src_valid is held high.
- Between bursts there is exactly one IDLE bubble cycle, even when requests are pending and space is available.
- wr_ptr_gray and wr_addr update on the edge that completes each write. At most one Gray bit changes per edge.
- burst_done is high in the same cycle as the final wr_en.
- A free-space check in IDLE uses the rd_ptr_gray value present in that cycle.

## Test plan
- Reset: hold rst_n = 0 with random inputs → gnt = 0, wr_en = 0, wr_ptr_gray = 0, free_cnt = 16, full = 0. Release → no activity until req.
- Single burst: req = 0100, src_valid = 1, rd_ptr_gray = 0 → gnt = 0100 for 4 cycles. wr_addr 0,1,2,3; wr_ptr_gray after each write 1,3,2,6; burst_done on beat 4; free_cnt = 12.
- Round-robin and full: req = 1111 held, rd_ptr_gray = 0 → grants 0001, 0010, 0100, 1000, each with one bubble. After 16 writes, full = 1 and free_cnt = 0, and gnt stays 0 despite req.
- Space release: from full, drive rd_ptr_gray = 6 (binary 4) → free_cnt = 4, next grant 0001 (continuing after channel 3). Drive rd_ptr_gray = 2 (binary 3) instead → free_cnt = 3, no grant.
- Stall and wrap: src_valid toggles 1,0,0,1,… → wr_en only in cycles where src_valid = 1, gnt held, pointer unchanged on stall cycles. Run to 32 writes with reads keeping pace → wr_ptr_gray goes 10000 → 00000 and wr_addr returns to 0.
- Reset mid-burst: assert rst_n = 0 after beat 2 → wr_en, gnt, and wr_ptr_gray drop to 0 asynchronously. After release, req = 0010 is granted first, after channel 0 if both request.

Source files
------------

// File: rtl/dma_fifo_wr_arbiter.sv
// rtl/dma_fifo_wr_arbiter.sv - round-robin burst write scheduler for the shared DMA FIFO
// Owns the binary/Gray write pointer and grants whole bursts only when space allows.
module dma_fifo_wr_arbiter #(
  parameter int PTR   = 4,
  parameter int NCH   = 4,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           src_valid,
  input  logic [PTR:0]   rd_ptr_gray,
  output logic [NCH-1:0] gnt,
  output logic           wr_en,
  output logic [PTR-1:0] wr_addr,
  output logic [PTR:0]   wr_ptr_gray,
  output logic [PTR:0]   free_cnt,
  output logic           full,
  output logic           burst_done
);

  localparam int LW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BCW = $clog2(BURST) + 1;
  localparam logic [PTR:0]   DEPTH     = (PTR+1)'(1 << PTR);
  localparam logic [PTR:0]   BURST_LEN = (PTR+1)'(BURST);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t         state;
  logic [PTR:0]   wr_bin;
  logic [PTR:0]   wr_bin_nxt;
  logic [PTR:0]   rd_bin;
  logic [PTR:0]   occupancy;
  logic [BCW-1:0] beat_cnt;
  logic [LW-1:0]  last;
  logic [LW-1:0]  cur_idx;
  logic [LW-1:0]  nxt_idx;
  logic           found;
  int             cand;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= PTR; i++) begin
      rd_bin[i] = ^(rd_ptr_gray >> i);
    end
  end

  assign occupancy  = wr_bin - rd_bin;
  assign free_cnt   = DEPTH - occupancy;
  assign full       = (free_cnt == '0);
  assign wr_addr    = wr_bin[PTR-1:0];
  assign wr_bin_nxt = wr_bin + 1'b1;
  assign wr_en      = (state == ST_BURST) && src_valid;
  assign burst_done = wr_en && (beat_cnt == LAST_BEAT);

  // Search starts one past the last served channel so every requester gets a turn.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NCH; i++) begin
      cand = (int'(last) + i) % NCH;
      if (!found && req[cand]) begin
        found   = 1'b1;
        nxt_idx = LW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      gnt         <= '0;
      beat_cnt    <= '0;
      last        <= LW'(NCH - 1);
      cur_idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found && (free_cnt >= BURST_LEN)) begin
            gnt      <= NCH'(1) << nxt_idx;
            cur_idx  <= nxt_idx;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (src_valid) begin
            wr_bin      <= wr_bin_nxt;
            wr_ptr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
            beat_cnt    <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              last  <= cur_idx;
              gnt   <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_fifo_wr_arbiter.sv
// tb/tb_dma_fifo_wr_arbiter.sv - directed self-checking bench for dma_fifo_wr_arbiter
module tb_dma_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       src_valid;
  logic [4:0] rd_ptr_gray;
  logic [3:0] gnt;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] free_cnt;
  logic       full;
  logic       burst_done;

  int         tests = 0;
  int         fails = 0;
  logic [4:0] wb;
  int         nb;

  always #5 clk = ~clk;

  dma_fifo_wr_arbiter #(.PTR(4), .NCH(4), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_valid(src_valid),
    .rd_ptr_gray(rd_ptr_gray), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ptr_gray(wr_ptr_gray), .free_cnt(free_cnt), .full(full),
    .burst_done(burst_done)
  );

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sv, input logic [3:0] eg);
    src_valid = sv;
    #1;
    chk("beat_wr_en", 32'(wr_en), 32'(sv));
    chk("beat_gnt", 32'(gnt), 32'(eg));
    chk("beat_wr_addr", 32'(wr_addr), 32'(wb[3:0]));
    chk("beat_burst_done", 32'(burst_done), 32'(sv && nb == 3));
    step();
    if (sv) begin
      wb++;
      nb++;
    end
    chk("beat_wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray(wb)));
  endtask

  task automatic do_burst(input logic [3:0] eg);
    nb = 0;
    for (int k = 0; k < 4; k++) beat(1'b1, eg);
    chk("bubble_gnt", 32'(gnt), 32'h0);
    chk("bubble_wr_en", 32'(wr_en), 32'h0);
    step();
  endtask

  initial begin
    logic sv_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n       = 1'b0;
    req         = 4'($urandom);
    src_valid   = 1'($urandom);
    rd_ptr_gray = 5'd0;
    wb          = 5'd0;
    nb          = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      req       = 4'($urandom);
      src_valid = 1'($urandom);
    end
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 32'h0);
    chk("rst_free_cnt", 32'(free_cnt), 32'd16);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_burst_done", 32'(burst_done), 32'h0);

    // Idle after release
    req = 4'b0000;
    src_valid = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_wr_en", 32'(wr_en), 32'h0);

    // Single burst on channel 2
    req = 4'b0100;
    step();
    req = 4'b0000;
    do_burst(4'b0100);
    chk("single_free_cnt", 32'(free_cnt), 32'd12);
    chk("single_gnt_after", 32'(gnt), 32'h0);

    // Round robin from a fresh reset until the FIFO is full
    rst_n = 1'b0;
    #1;
    chk("rst2_wr_ptr_gray", 32'(wr_ptr_gray), 32'h0);
    step();
    rst_n = 1'b1;
    wb = 5'd0;
    req = 4'b1111;
    step();
    do_burst(4'b0001);
    do_burst(4'b0010);
    do_burst(4'b0100);
    do_burst(4'b1000);
    chk("full_flag", 32'(full), 32'h1);
    chk("full_free_cnt", 32'(free_cnt), 32'd0);
    step();
    step();
    chk("full_no_gnt", 32'(gnt), 32'h0);

    // Three entries freed is not enough, four is
    rd_ptr_gray = 5'd2;
    #1;
    chk("free3_free_cnt", 32'(free_cnt), 32'd3);
    step();
    step();
    chk("free3_no_gnt", 32'(gnt), 32'h0);
    rd_ptr_gray = 5'd6;
    #1;
    chk("free4_free_cnt", 32'(free_cnt), 32'd4);
    step();
    do_burst(4'b0001);

    // Reader catches up to 20; stalled burst on channel 1
    rd_ptr_gray = gray(5'd20);
    step();
    nb = 0;
    for (int k = 0; k < 7; k++) beat(sv_pat[k], 4'b0010);
    chk("stall_bubble_gnt", 32'(gnt), 32'h0);
    step();
    do_burst(4'b0100);
    do_burst(4'b1000);
    chk("wrap_wr_ptr_gray", 32'(wr_ptr_gray), 32'h0);
    chk("wrap_wr_addr", 32'(wr_addr), 32'h0);

    // Reset in the middle of the next burst
    nb = 0;
    beat(1'b1, 4'b0001);
    beat(1'b1, 4'b0001);
    rst_n = 1'b0;
    rd_ptr_gray = 5'd0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_wr_ptr_gray", 32'(wr_ptr_gray), 32'h0);
    chk("midrst_free_cnt", 32'(free_cnt), 32'd16);
    step();
    rst_n = 1'b1;
    wb = 5'd0;
    req = 4'b0011;
    step();
    do_burst(4'b0001);
    do_burst(4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
